cd_quad_responder: RTL and testbench
====================================

# cd_quad_responder

Quadrant-side responder terminating the converged request channels that the local 4-to-2 concentrator drives toward the global level. It accepts request flits on two converged channels and buffers each channel in its own FIFO. After a programmable service latency it returns one reply flit per request on the matching converged reply channel. Each reply keeps the requester's srcx/srcy, so the concentrator's reply path steers it back to the originating tile.

## Interface
- DATA_W, 64: flit width; the header layout requires exactly 64.
- DEPTH, 4: entries per channel FIFO; a power of two, ≥2.
- LAT, 2: service cycles per request at the FIFO head; range 0..15.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low (0 = reset), sampled on clk.
- cv_si  in  2  request valid, one bit per converged channel.
- cv_ri  out  2  request ready per channel.
- cv_di  in  2*DATA_W  request flits; channel i occupies [DATA_W*(i+1)-1 : DATA_W*i].
- cv_so_r  out  2  reply valid per channel.
- cv_ro_r  in  2  reply ready per channel.
- cv_do_r  out  2*DATA_W  reply flits, same slicing as cv_di.

## Operation
- Flit layout:
  - [63] vc
  - [62] dx
  - [61] dy
  - [60:56] rsv
  - [55:52] hx
  - [51:48] hy
  - [47:40] srcx
  - [39:32] srcy
  - [31:0] payload
- Transfer rule: a transfer happens on a channel iff valid and ready are both 1 at the clock edge.
  - Valid never depends combinationally on ready.
  - Ready is never gated by valid.
- Channels 0 and 1 are fully independent. A request on channel i is always answered on reply channel i.
- Request side: cv_ri[i] = ~full[i], driven from registered state only.
  - A push is refused when full, even if a pop occurs in the same cycle. There is no full-bypass.
- Per-channel state machine with states IDLE, SERVE and PRESENT:
  - IDLE: FIFO empty. Moves to SERVE when an entry becomes the head; the countdown loads LAT.
  - SERVE: the countdown decrements each cycle. Moves to PRESENT when the count is 0; with LAT=0, SERVE lasts zero cycles.
  - PRESENT: cv_so_r[i]=1. On a reply transfer, pop the head, then go to SERVE (countdown reloads LAT) if the FIFO is still non-empty, else to IDLE.
- Reply formation, combinational from the head entry:
  - All header fields are copied unchanged, except rsv[4], which is forced to 1 (reply flag).
  - payload = head payload + 1, modulo 2^32.
- Hold rule: while cv_so_r[i]=1 and cv_ro_r[i]=0, cv_so_r[i] and cv_do_r slice i hold stable.
- Data when idle: cv_do_r slice i is all zeros whenever cv_so_r[i]=0.
- FIFO pointers are log2(DEPTH) bits wide and wrap naturally. The occupancy counter is log2(DEPTH)+1 bits wide.

## Timing
- Reset values:
  - cv_ri = 2'b11
  - cv_so_r = 2'b00
  - cv_do_r = 0
  - FIFOs empty; all state machines in IDLE; countdowns 0.
- Reset asserted mid-operation flushes all entries, including a reply held under backpressure. No reply is emitted for a flushed entry.
- Latency: a request accepted at edge t into an empty FIFO raises cv_so_r in cycle t+1+LAT.
- Throughput:
  - LAT=0 with cv_ro_r held at 1 gives one reply per cycle.
  - LAT=L>0 gives one reply per L+1 cycles.
- A push into an empty FIFO has no bypass: the reply always waits at least one cycle after acceptance.
- A simultaneous push and pop when not full is legal; occupancy is unchanged.

## Configuration
- CD_RESP_STATS_EN defined:
  - Adds outputs req_cnt (2*16) and rsp_cnt (2*16): per-channel counters of request and reply transfers.
  - Counters reset to 0, saturate at 16'hFFFF, and update on the transfer edge.
- CD_RESP_STATS_EN undefined: these ports and counters do not exist. All other behaviour is identical.

## Structure
- Package cd_pkg:
  - DATA_W
  - header field MSB/LSB constants
  - RSV_REPLY_BIT = 4
  - LAT_W = 4
- Header decode reuses the existing hdr_fields module, one instance per channel head.
- Sub-module cd_resp_fifo (parameter DEPTH):
  - push/pop/full/empty/head interface.
  - Instantiated twice.
  - Contains no latency logic.
- The state machine, countdown and reply formation live in the top level, one copy per channel via a generate block.

## Test plan
- Single request, LAT=2: channel 0 receives srcx=8'h01, srcy=8'h00, payload 32'h0000_00FF at edge 10 → cv_so_r[0]=1 in cycle 13 with payload 32'h0000_0100, rsv[4]=1 and srcx/srcy unchanged.
- Fill and refuse, DEPTH=4: cv_ro_r=0 and 5 back-to-back requests on channel 1 → cv_ri[1]=0 after the 4th accept, the 5th is not taken, and cv_do_r slice 1 stays stable while stalled.
- Backpressure release: hold cv_ro_r[0]=0 for 6 cycles, then 1 → exactly one reply transfer; the next reply appears LAT+1 cycles later.
- Wrap-around: send 10 requests through DEPTH=4 with cv_ro_r=1 → replies keep request order, each payload +1, including 32'hFFFF_FFFF → 32'h0000_0000.
- Independence: both channels active, channel 1 stalled → channel 0 continues at full LAT rate.
- Reset mid-operation: assert reset with 3 queued entries → next cycle cv_so_r=0, cv_ri=2'b11, and no stale replies after release. With CD_RESP_STATS_EN defined, the counters read 0.

Source files
------------

// File: rtl/cd_pkg.sv
// cd_pkg: shared constants and types for the quadrant-side responder.
//   DATA_W          flit width (the header layout fixes it at 64)
//   *_MSB / *_LSB   header field positions inside a flit
//   RSV_REPLY_BIT   bit of the rsv field that marks a flit as a reply
//   LAT_W           width of the service-latency countdown
//   resp_st_e       per-channel reply state machine encoding
package cd_pkg;

    localparam int unsigned DATA_W = 64;

    localparam int unsigned VC_BIT   = 63;
    localparam int unsigned DX_BIT   = 62;
    localparam int unsigned DY_BIT   = 61;
    localparam int unsigned RSV_MSB  = 60;
    localparam int unsigned RSV_LSB  = 56;
    localparam int unsigned HX_MSB   = 55;
    localparam int unsigned HX_LSB   = 52;
    localparam int unsigned HY_MSB   = 51;
    localparam int unsigned HY_LSB   = 48;
    localparam int unsigned SRCX_MSB = 47;
    localparam int unsigned SRCX_LSB = 40;
    localparam int unsigned SRCY_MSB = 39;
    localparam int unsigned SRCY_LSB = 32;
    localparam int unsigned PAY_MSB  = 31;
    localparam int unsigned PAY_LSB  = 0;

    localparam int unsigned RSV_W  = RSV_MSB - RSV_LSB + 1;
    localparam int unsigned HX_W   = HX_MSB - HX_LSB + 1;
    localparam int unsigned HY_W   = HY_MSB - HY_LSB + 1;
    localparam int unsigned SRCX_W = SRCX_MSB - SRCX_LSB + 1;
    localparam int unsigned SRCY_W = SRCY_MSB - SRCY_LSB + 1;
    localparam int unsigned PAY_W  = PAY_MSB - PAY_LSB + 1;

    localparam int unsigned RSV_REPLY_BIT = 4;
    localparam int unsigned LAT_W         = 4;

    typedef enum logic [1:0] {
        StIdle,
        StServe,
        StPresent
    } resp_st_e;

endpackage

// File: rtl/cd_resp_fifo.sv
// cd_resp_fifo: per-channel request buffer, plain circular FIFO.
//   clk_i, rst_ni  clock and synchronous active-low reset
//   push_i         write wdata_i (ignored when full, even if popping)
//   pop_i          drop the head entry (ignored when empty)
//   full_o/empty_o occupancy flags, from registered state only
//   head_o         oldest entry; stable until popped
//   cnt_o          occupancy, 0..DEPTH
module cd_resp_fifo
    import cd_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic [DATA_W-1:0]       wdata_i,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [DATA_W-1:0]       head_o,
    output logic [$clog2(DEPTH):0]  cnt_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W:0]    cnt_q;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (cnt_q == (PTR_W + 1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign cnt_o   = cnt_q;

    // No full-bypass: a push is refused while full regardless of a pop.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            // Pointers are log2(DEPTH) wide and wrap on their own.
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + (PTR_W + 1)'(1);
            end else if (do_pop && !do_push) begin
                cnt_q <= cnt_q - (PTR_W + 1)'(1);
            end
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/hdr_fields.sv
// hdr_fields: splits a flit into its header fields and payload.
//   flit_i     full flit
//   vc_o, dx_o, dy_o, rsv_o, hx_o, hy_o, srcx_o, srcy_o   header fields
//   payload_o  low payload word
module hdr_fields
    import cd_pkg::*;
(
    input  logic [DATA_W-1:0] flit_i,
    output logic              vc_o,
    output logic              dx_o,
    output logic              dy_o,
    output logic [RSV_W-1:0]  rsv_o,
    output logic [HX_W-1:0]   hx_o,
    output logic [HY_W-1:0]   hy_o,
    output logic [SRCX_W-1:0] srcx_o,
    output logic [SRCY_W-1:0] srcy_o,
    output logic [PAY_W-1:0]  payload_o
);

    assign vc_o      = flit_i[VC_BIT];
    assign dx_o      = flit_i[DX_BIT];
    assign dy_o      = flit_i[DY_BIT];
    assign rsv_o     = flit_i[RSV_MSB:RSV_LSB];
    assign hx_o      = flit_i[HX_MSB:HX_LSB];
    assign hy_o      = flit_i[HY_MSB:HY_LSB];
    assign srcx_o    = flit_i[SRCX_MSB:SRCX_LSB];
    assign srcy_o    = flit_i[SRCY_MSB:SRCY_LSB];
    assign payload_o = flit_i[PAY_MSB:PAY_LSB];

endmodule

// File: rtl/cd_quad_responder.sv
// cd_quad_responder: terminates the two converged request channels and returns one
// reply per request on the matching reply channel after LAT service cycles.
//   clk, reset        clock and synchronous active-low reset
//   cv_si/cv_ri/cv_di request valid/ready/flits, channel i in [64*i +: 64]
//   cv_so_r/cv_ro_r/cv_do_r  reply valid/ready/flits, same slicing
//   req_cnt/rsp_cnt   per-channel saturating transfer counters (16 bits each),
//                     present only when CD_RESP_STATS_EN is defined
// A reply copies the request header with the reply flag set in rsv and returns
// payload + 1, so srcx/srcy steer it back to the requesting tile.
module cd_quad_responder
    import cd_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LAT   = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          cv_si,
    output logic [1:0]          cv_ri,
    input  logic [2*DATA_W-1:0] cv_di,
    output logic [1:0]          cv_so_r,
    input  logic [1:0]          cv_ro_r,
    output logic [2*DATA_W-1:0] cv_do_r
`ifdef CD_RESP_STATS_EN
    ,
    output logic [2*16-1:0]     req_cnt,
    output logic [2*16-1:0]     rsp_cnt
`endif
);

    localparam int unsigned    CNT_W    = $clog2(DEPTH) + 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LAT);
    localparam bit             LAT_ZERO = (LAT == 0);
    localparam logic [RSV_W-1:0] REPLY_MASK = RSV_W'(1) << RSV_REPLY_BIT;

    for (genvar i = 0; i < 2; i++) begin : g_ch
        logic              full;
        logic              empty;
        logic              push;
        logic              pop;
        logic [CNT_W-1:0]  occ;
        logic [DATA_W-1:0] head;
        logic [DATA_W-1:0] reply;
        resp_st_e          st_q;
        logic [LAT_W-1:0]  cd_q;

        logic              h_vc;
        logic              h_dx;
        logic              h_dy;
        logic [RSV_W-1:0]  h_rsv;
        logic [HX_W-1:0]   h_hx;
        logic [HY_W-1:0]   h_hy;
        logic [SRCX_W-1:0] h_srcx;
        logic [SRCY_W-1:0] h_srcy;
        logic [PAY_W-1:0]  h_pay;

        assign cv_ri[i] = ~full;
        assign push     = cv_si[i] & ~full;
        assign pop      = (st_q == StPresent) & cv_ro_r[i];

        cd_resp_fifo #(
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk_i   (clk),
            .rst_ni  (reset),
            .push_i  (push),
            .pop_i   (pop),
            .wdata_i (cv_di[DATA_W*i +: DATA_W]),
            .full_o  (full),
            .empty_o (empty),
            .head_o  (head),
            .cnt_o   (occ)
        );

        hdr_fields u_hdr (
            .flit_i    (head),
            .vc_o      (h_vc),
            .dx_o      (h_dx),
            .dy_o      (h_dy),
            .rsv_o     (h_rsv),
            .hx_o      (h_hx),
            .hy_o      (h_hy),
            .srcx_o    (h_srcx),
            .srcy_o    (h_srcy),
            .payload_o (h_pay)
        );

        assign reply = {h_vc, h_dx, h_dy, h_rsv | REPLY_MASK, h_hx, h_hy,
                        h_srcx, h_srcy, h_pay + PAY_W'(1)};

        // SERVE lasts exactly LAT cycles: the count reaches 0 on the edge that
        // enters PRESENT. With LAT=0 the state is skipped entirely.
        always_ff @(posedge clk) begin
            if (!reset) begin
                st_q <= StIdle;
                cd_q <= '0;
            end else begin
                unique case (st_q)
                    StIdle: begin
                        if (!empty) begin
                            if (LAT_ZERO) begin
                                st_q <= StPresent;
                            end else begin
                                st_q <= StServe;
                                cd_q <= LAT_LOAD;
                            end
                        end
                    end
                    StServe: begin
                        cd_q <= cd_q - LAT_W'(1);
                        if (cd_q == LAT_W'(1)) st_q <= StPresent;
                    end
                    StPresent: begin
                        if (cv_ro_r[i]) begin
                            // Only entries queued before this edge count as the next head;
                            // an entry pushed on this edge starts from IDLE so it still sees
                            // the full acceptance-to-reply latency.
                            if (occ > CNT_W'(1)) begin
                                if (LAT_ZERO) begin
                                    st_q <= StPresent;
                                end else begin
                                    st_q <= StServe;
                                    cd_q <= LAT_LOAD;
                                end
                            end else begin
                                st_q <= StIdle;
                            end
                        end
                    end
                    default: begin
                        st_q <= StIdle;
                        cd_q <= '0;
                    end
                endcase
            end
        end

        assign cv_so_r[i]                 = (st_q == StPresent);
        assign cv_do_r[DATA_W*i +: DATA_W] = cv_so_r[i] ? reply : '0;

`ifdef CD_RESP_STATS_EN
        logic [15:0] req_cnt_q;
        logic [15:0] rsp_cnt_q;

        always_ff @(posedge clk) begin
            if (!reset) begin
                req_cnt_q <= '0;
                rsp_cnt_q <= '0;
            end else begin
                if (push && req_cnt_q != 16'hFFFF) req_cnt_q <= req_cnt_q + 16'd1;
                if (pop && rsp_cnt_q != 16'hFFFF)  rsp_cnt_q <= rsp_cnt_q + 16'd1;
            end
        end

        assign req_cnt[16*i +: 16] = req_cnt_q;
        assign rsp_cnt[16*i +: 16] = rsp_cnt_q;
`endif
    end

endmodule

// File: tb/tb_cd_quad_responder.sv
// Directed bench for cd_quad_responder (DEPTH=4, LAT=2).
module tb_cd_quad_responder;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [1:0]   cv_si = 2'b00;
    logic [1:0]   cv_ri;
    logic [127:0] cv_di = '0;
    logic [1:0]   cv_so_r;
    logic [1:0]   cv_ro_r = 2'b00;
    logic [127:0] cv_do_r;
`ifdef CD_RESP_STATS_EN
    logic [31:0]  req_cnt;
    logic [31:0]  rsp_cnt;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    cd_quad_responder #(
        .DEPTH (4),
        .LAT   (2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .cv_si   (cv_si),
        .cv_ri   (cv_ri),
        .cv_di   (cv_di),
        .cv_so_r (cv_so_r),
        .cv_ro_r (cv_ro_r),
        .cv_do_r (cv_do_r)
`ifdef CD_RESP_STATS_EN
        ,
        .req_cnt (req_cnt),
        .rsp_cnt (rsp_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] mk_flit(input logic [7:0] top8, input logic [7:0] hxy,
                                            input logic [7:0] srcx, input logic [7:0] srcy,
                                            input logic [31:0] payload);
        return {top8, hxy, srcx, srcy, payload};
    endfunction

    // Reply: rsv[4] (flit bit 60) forced to 1, payload + 1 mod 2^32.
    function automatic logic [63:0] exp_reply(input logic [63:0] f);
        logic [63:0] r;
        r = f;
        r[60] = 1'b1;
        r[31:0] = f[31:0] + 32'd1;
        return r;
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        total++;
        if (cv_ri !== 2'b11) begin bad++; $display("FAIL reset_ri: got %b want 11", cv_ri); end
        total++;
        if (cv_so_r !== 2'b00) begin bad++; $display("FAIL reset_so: got %b want 00", cv_so_r); end
        total++;
        if (cv_do_r !== 128'd0) begin bad++; $display("FAIL reset_do: got %h want 0", cv_do_r); end
`ifdef CD_RESP_STATS_EN
        total++;
        if (req_cnt !== 32'd0 || rsp_cnt !== 32'd0) begin
            bad++; $display("FAIL reset_stats: got %h/%h want 0/0", req_cnt, rsp_cnt);
        end
`endif
        reset = 1'b1;
        tick();
        total++;
        if (cv_so_r !== 2'b00 || cv_ri !== 2'b11) begin
            bad++; $display("FAIL reset_release: got so=%b ri=%b want 00/11", cv_so_r, cv_ri);
        end
    endtask

    task automatic test_single();
        logic [63:0] f;
        logic [63:0] exp;
        f   = mk_flit(8'h00, 8'h00, 8'h01, 8'h00, 32'h0000_00FF);
        exp = 64'h1000_0100_0000_0100;
        cv_ro_r = 2'b00;
        cv_si = 2'b01;
        cv_di[63:0] = f;
        tick();                       // accepted here (edge t)
        cv_si = 2'b00;
        cv_di = '0;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) tick();
            total++;
            if (cv_so_r[0] !== 1'b0) begin
                bad++; $display("FAIL single_early: cycle t+%0d so=%b want 0", c, cv_so_r[0]);
            end
        end
        tick();                       // cycle t+1+LAT
        total++;
        if (cv_so_r[0] !== 1'b1 || cv_do_r[63:0] !== exp) begin
            bad++;
            $display("FAIL single_reply: got so=%b do=%h want 1 %h", cv_so_r[0], cv_do_r[63:0], exp);
        end
        for (int c = 0; c < 2; c++) begin
            tick();
            total++;
            if (cv_so_r[0] !== 1'b1 || cv_do_r[63:0] !== exp) begin
                bad++; $display("FAIL single_hold: got so=%b do=%h want 1 %h", cv_so_r[0],
                                cv_do_r[63:0], exp);
            end
        end
        cv_ro_r[0] = 1'b1;
        tick();
        cv_ro_r[0] = 1'b0;
        total++;
        if (cv_so_r[0] !== 1'b0 || cv_do_r[63:0] !== 64'd0) begin
            bad++; $display("FAIL single_after: got so=%b do=%h want 0 0", cv_so_r[0], cv_do_r[63:0]);
        end
    endtask

    task automatic test_fill();
        logic [63:0] fl [5];
        logic [63:0] held;
        for (int k = 0; k < 5; k++) begin
            fl[k] = mk_flit(8'(8'hA0 + k), 8'h3C, 8'(8'h10 + k), 8'h20, 32'h1000_0000 + k);
        end
        cv_ro_r = 2'b00;
        cv_si[1] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            total++;
            if (cv_ri[1] !== (k < 4 ? 1'b1 : 1'b0)) begin
                bad++; $display("FAIL fill_ready: req %0d got ri=%b want %b", k, cv_ri[1], k < 4);
            end
            cv_di[127:64] = fl[k];
            tick();
        end
        cv_si[1] = 1'b0;
        cv_di = '0;
        held = exp_reply(fl[0]);
        for (int c = 0; c < 3; c++) begin
            total++;
            if (cv_so_r[1] !== 1'b1 || cv_do_r[127:64] !== held) begin
                bad++; $display("FAIL fill_stall: got so=%b do=%h want 1 %h", cv_so_r[1],
                                cv_do_r[127:64], held);
            end
            tick();
        end
        cv_ro_r[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            int w = 0;
            while (cv_so_r[1] !== 1'b1 && w < 20) begin tick(); w++; end
            total++;
            if (cv_so_r[1] !== 1'b1) begin
                bad++; $display("FAIL fill_drain: reply %0d timeout so=%b want 1", k, cv_so_r[1]);
            end else if (cv_do_r[127:64] !== exp_reply(fl[k])) begin
                bad++; $display("FAIL fill_drain: reply %0d got %h want %h", k, cv_do_r[127:64],
                                exp_reply(fl[k]));
            end
            tick();
        end
        begin
            int extra = 0;
            for (int c = 0; c < 8; c++) begin
                if (cv_so_r[1] === 1'b1) extra++;
                tick();
            end
            total++;
            if (extra != 0) begin
                bad++; $display("FAIL fill_refused: got %0d extra reply cycles want 0", extra);
            end
        end
        cv_ro_r[1] = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [63:0] a;
        logic [63:0] b;
        a = mk_flit(8'h40, 8'h12, 8'h02, 8'h03, 32'hDEAD_BEEF);
        b = mk_flit(8'h90, 8'h21, 8'h04, 8'h05, 32'h0000_0010);
        cv_ro_r = 2'b00;
        cv_si = 2'b01;
        cv_di[63:0] = a;
        tick();
        cv_di[63:0] = b;
        tick();
        cv_si = 2'b00;
        cv_di = '0;
        tick();
        tick();                       // a presented from here on
        for (int c = 0; c < 6; c++) begin
            total++;
            if (cv_so_r[0] !== 1'b1 || cv_do_r[63:0] !== 64'h5012_0203_DEAD_BEF0) begin
                bad++; $display("FAIL bp_hold: cycle %0d got so=%b do=%h want 1 5012_0203_DEAD_BEF0",
                                c, cv_so_r[0], cv_do_r[63:0]);
            end
            if (c < 5) tick();
        end
        cv_ro_r[0] = 1'b1;
        tick();                       // one transfer
        cv_ro_r[0] = 1'b0;
        for (int c = 0; c < 2; c++) begin
            total++;
            if (cv_so_r[0] !== 1'b0) begin
                bad++; $display("FAIL bp_gap: cycle %0d after transfer so=%b want 0", c, cv_so_r[0]);
            end
            tick();
        end
        total++;
        if (cv_so_r[0] !== 1'b1 || cv_do_r[63:0] !== 64'h9021_0405_0000_0011) begin
            bad++; $display("FAIL bp_next: got so=%b do=%h want 1 9021_0405_0000_0011",
                            cv_so_r[0], cv_do_r[63:0]);
        end
        cv_ro_r[0] = 1'b1;
        tick();
        cv_ro_r[0] = 1'b0;
        total++;
        if (cv_so_r[0] !== 1'b0) begin
            bad++; $display("FAIL bp_empty: got so=%b want 0", cv_so_r[0]);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] pl [10];
        logic [63:0] fl [10];
        pl = '{32'h0000_0001, 32'h7FFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0000_0000,
               32'hAAAA_5555, 32'h8000_0000, 32'hFFFF_FFFE, 32'h0F0F_0F0F, 32'hCAFE_F00D};
        for (int k = 0; k < 10; k++) begin
            fl[k] = mk_flit(8'(k << 5), 8'(k), 8'(8'h30 + k), 8'(k * 3), pl[k]);
        end
        fork
            begin
                for (int k = 0; k < 10; k++) begin
                    int w = 0;
                    cv_si[0] = 1'b1;
                    cv_di[63:0] = fl[k];
                    while (cv_ri[0] !== 1'b1 && w < 100) begin tick(); w++; end
                    tick();
                end
                cv_si[0] = 1'b0;
                cv_di[63:0] = '0;
            end
            begin
                cv_ro_r[0] = 1'b1;
                for (int k = 0; k < 10; k++) begin
                    int w = 0;
                    while (cv_so_r[0] !== 1'b1 && w < 100) begin tick(); w++; end
                    total++;
                    if (cv_so_r[0] !== 1'b1) begin
                        bad++; $display("FAIL wrap_order: reply %0d timeout", k);
                    end else if (cv_do_r[63:0] !== exp_reply(fl[k])) begin
                        bad++; $display("FAIL wrap_order: reply %0d got %h want %h", k,
                                        cv_do_r[63:0], exp_reply(fl[k]));
                    end
                    tick();
                end
            end
        join
        tick();
        cv_ro_r[0] = 1'b0;
        total++;
        if (cv_so_r[0] !== 1'b0 || cv_ri[0] !== 1'b1) begin
            bad++; $display("FAIL wrap_empty: got so=%b ri=%b want 0 1", cv_so_r[0], cv_ri[0]);
        end
    endtask

    task automatic test_independence();
        logic [63:0] f [3];
        logic [63:0] g;
        int got = 0;
        f[0] = mk_flit(8'h20, 8'h11, 8'h05, 8'h06, 32'h0000_1000);
        f[1] = mk_flit(8'h21, 8'h22, 8'h07, 8'h08, 32'h0000_2000);
        f[2] = mk_flit(8'h22, 8'h33, 8'h09, 8'h0A, 32'h0000_3000);
        g    = mk_flit(8'hC1, 8'h44, 8'h0B, 8'h0C, 32'h5555_AAAA);
        cv_ro_r = 2'b01;
        cv_si = 2'b11;
        cv_di = {g, f[0]};
        tick();                       // cycle 0
        cv_si = 2'b01;
        cv_di = {64'd0, f[1]};
        tick();                       // cycle 1
        cv_di[63:0] = f[2];
        tick();                       // cycle 2
        cv_si = 2'b00;
        cv_di = '0;
        for (int cyc = 2; cyc <= 12; cyc++) begin
            if (cyc > 2) tick();
            if (cv_so_r[0] === 1'b1) begin
                total++;
                if (got >= 3) begin
                    bad++; $display("FAIL indep_rate: extra reply at cycle %0d", cyc);
                end else if (cyc != 3 + 3 * got || cv_do_r[63:0] !== exp_reply(f[got])) begin
                    bad++; $display("FAIL indep_rate: reply %0d at cycle %0d data %h want cycle %0d %h",
                                    got, cyc, cv_do_r[63:0], 3 + 3 * got, exp_reply(f[got]));
                end
                got++;
            end
        end
        total++;
        if (got != 3) begin bad++; $display("FAIL indep_count: got %0d replies want 3", got); end
        total++;
        if (cv_so_r[1] !== 1'b1 || cv_do_r[127:64] !== 64'hD144_0B0C_5555_AAAB) begin
            bad++; $display("FAIL indep_stalled: got so=%b do=%h want 1 D144_0B0C_5555_AAAB",
                            cv_so_r[1], cv_do_r[127:64]);
        end
        cv_ro_r = 2'b10;
        tick();
        cv_ro_r = 2'b00;
        total++;
        if (cv_so_r !== 2'b00) begin bad++; $display("FAIL indep_drain: got so=%b want 00", cv_so_r); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] z;
        int stale = 0;
        int w = 0;
        cv_ro_r = 2'b00;
        cv_si = 2'b11;
        for (int k = 0; k < 3; k++) begin
            cv_di = {mk_flit(8'h60, 8'h00, 8'(k), 8'h01, 32'd100 + k),
                     mk_flit(8'h70, 8'h00, 8'(k), 8'h02, 32'd200 + k)};
            tick();
        end
        cv_si = 2'b00;
        cv_di = '0;
        tick();
        total++;
        if (cv_so_r !== 2'b11) begin bad++; $display("FAIL mid_pre: got so=%b want 11", cv_so_r); end
        reset = 1'b0;
        tick();
        total++;
        if (cv_so_r !== 2'b00 || cv_ri !== 2'b11 || cv_do_r !== 128'd0) begin
            bad++; $display("FAIL mid_reset: got so=%b ri=%b do=%h want 00 11 0", cv_so_r, cv_ri,
                            cv_do_r);
        end
`ifdef CD_RESP_STATS_EN
        total++;
        if (req_cnt !== 32'd0 || rsp_cnt !== 32'd0) begin
            bad++; $display("FAIL mid_stats: got %h/%h want 0/0", req_cnt, rsp_cnt);
        end
`endif
        reset = 1'b1;
        cv_ro_r = 2'b11;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (cv_so_r !== 2'b00) stale++;
        end
        total++;
        if (stale != 0) begin bad++; $display("FAIL mid_stale: got %0d reply cycles want 0", stale); end
        z = mk_flit(8'h05, 8'h77, 8'h0E, 8'h0F, 32'h0000_0041);
        cv_si = 2'b10;
        cv_di[127:64] = z;
        tick();
        cv_si = 2'b00;
        cv_di = '0;
        while (cv_so_r[1] !== 1'b1 && w < 20) begin tick(); w++; end
        total++;
        if (cv_so_r[1] !== 1'b1 || cv_do_r[127:64] !== 64'h1577_0E0F_0000_0042) begin
            bad++; $display("FAIL mid_fresh: got so=%b do=%h want 1 1577_0E0F_0000_0042",
                            cv_so_r[1], cv_do_r[127:64]);
        end
        tick();
        cv_ro_r = 2'b00;
`ifdef CD_RESP_STATS_EN
        total++;
        if (req_cnt !== 32'h0001_0000 || rsp_cnt !== 32'h0001_0000) begin
            bad++; $display("FAIL mid_stats_count: got %h/%h want 00010000/00010000", req_cnt,
                            rsp_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_backpressure();
        test_wrap();
        test_independence();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
